// File: rtl/rle_compressor_pkg.sv
// Shared definitions for the run-length compressor/decompressor pair.
// Token width and state encoding live here so both ends agree on them.
package rle_compressor_pkg;

  // Default word width in bits.
  localparam int N_DEFAULT = 32;

  // Token value width: must hold the value N itself (runs are capped at N).
  localparam int CNT_W_DEFAULT = $clog2(N_DEFAULT) + 1;

  // Compressor FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // Token value width for an arbitrary word width.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/rle_run_finder.sv
// Combinational run finder: length of the run of bits equal to word[pos],
// starting at pos and bounded by the top of the word. Implemented as a
// masked priority encoder for the first differing bit at or above pos.
module rle_run_finder
  import rle_compressor_pkg::*;
#(
  parameter int N = N_DEFAULT,
  localparam int CNT_W = cnt_width(N)
) (
  input  logic [N-1:0] word,
  input  logic [CNT_W:0] pos,
  output logic [CNT_W:0] seg
);

  localparam int CW1 = CNT_W + 1;
  localparam int IW  = $clog2(N);

  logic           ref_bit;
  logic [CW1-1:0] first;

  // Lowest index >= pos whose bit differs from word[pos]; N if none.
  always_comb begin
    ref_bit = word[pos[IW-1:0]];
    first   = CW1'(N);
    for (int i = N - 1; i >= 0; i--) begin
      if ((CW1'(i) >= pos) && (word[i] != ref_bit)) begin
        first = CW1'(i);
      end
    end
    // pos == N gives first == N and therefore seg == 0.
    seg = first - pos;
  end

endmodule

// File: rtl/rle_compressor.sv
// Run-length compressor: scans N-bit words LSB first and emits
// (bit, length) tokens, merging runs across word boundaries and capping
// every token at N.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The token register holds its fields while out_valid is high
// and out_ready is low; in_ready depends only on the FSM state.
module rle_compressor
  import rle_compressor_pkg::*;
#(
  parameter int N = N_DEFAULT,
  localparam int CNT_W = cnt_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [CNT_W-1:0] out_value,
  output logic             done
);

  localparam int CW1 = CNT_W + 1;
  localparam int IW  = $clog2(N);
  localparam logic [CW1-1:0] FULL = CW1'(N);

  logic [1:0]     state;
  logic [N-1:0]   word_r;
  logic [CW1-1:0] pos;
  logic           acc_bit;
  logic [CW1-1:0] acc_cnt;
  logic           last_r;

  logic [CW1-1:0] seg;
  logic [CW1-1:0] room;
  logic [CW1-1:0] take;
  logic           cur_bit;
  logic           load_ok;

  rle_run_finder #(.N(N)) u_run_finder (
    .word (word_r),
    .pos  (pos),
    .seg  (seg)
  );

  // Datapath helpers: current bit, room left in the accumulator, and how
  // much of the current segment fits without exceeding N.
  always_comb begin
    cur_bit  = word_r[pos[IW-1:0]];
    room     = FULL - acc_cnt;
    take     = (seg < room) ? seg : room;
    load_ok  = ~out_valid | out_ready;
    in_ready = (state == ST_IDLE);
  end

  // FSM, run accumulator and output token register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      word_r    <= '0;
      pos       <= '0;
      acc_bit   <= 1'b0;
      acc_cnt   <= '0;
      last_r    <= 1'b0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_value <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // A transferred token retires unless a new one loads below.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          // acc_bit/acc_cnt are kept so a run continues into this word.
          if (in_valid) begin
            word_r <= in_data;
            last_r <= in_last;
            pos    <= '0;
            state  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (pos == FULL) begin
            // Word exhausted: wait for the next one or flush the stream.
            if (!last_r) begin
              state <= ST_IDLE;
            end else if (acc_cnt == '0) begin
              state <= ST_FLUSH;
            end else if (load_ok) begin
              out_valid <= 1'b1;
              out_bit   <= acc_bit;
              out_value <= acc_cnt[CNT_W-1:0];
              acc_cnt   <= '0;
              state     <= ST_FLUSH;
            end
          end else if ((acc_cnt == FULL) ||
                       ((acc_cnt != '0) && (cur_bit != acc_bit))) begin
            // Full accumulator or run broken: emit, pos stays put.
            if (load_ok) begin
              out_valid <= 1'b1;
              out_bit   <= acc_bit;
              out_value <= acc_cnt[CNT_W-1:0];
              acc_cnt   <= '0;
            end
          end else begin
            // Absorb as much of the current segment as fits.
            acc_bit <= cur_bit;
            acc_cnt <= acc_cnt + take;
            pos     <= pos + take;
          end
        end
        ST_FLUSH: begin
          // Wait for the final token to leave, then signal completion.
          if (load_ok) begin
            done    <= 1'b1;
            acc_cnt <= '0;
            acc_bit <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
